mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle data-memory access sequencer between the decoder's memory control outputs and an external handshaked data-memory bus. It converts a decoded load or store into one word-aligned bus transaction with byte enables. It stalls the PC/register-write path until the bus acknowledges, then returns the lane-extracted, sign- or zero-extended load data. It also flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum number of REQ cycles before the access is aborted. Legal range is 1–65535.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memread` in 1: load request from the decoder.
- `memwrite` in 1: store request from the decoder.
- `mem_length` in 2: access size. 00 = none, 01 = byte, 10 = halfword, 11 = word.
- `mem_signed` in 1: sign-extend the load result.
- `addr` in 32: byte address from the ALU.
- `wdata` in 32: store data, taken from rt.
- `stall` out 1: freeze PC and suppress register write while high.
- `done` out 1: one-cycle pulse. `rdata` and `bus_err` are valid in this cycle.
- `rdata` out 32: extended load result.
- `addr_err` out 1: misaligned access detected. Combinational, valid in IDLE.
- `bus_err` out 1: timeout flag, valid while `done` is high.
- `bus_req` out 1: request to memory.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, with bits [1:0] forced to 0.
- `bus_be` out 4: byte enables. Bit i corresponds to byte lane i (little-endian).
- `bus_wdata` out 32: lane-replicated store data.
- `bus_rdata` in 32: read data, valid when `bus_ack` is high.
- `bus_ack` in 1: completes the transaction in the cycle it is sampled high.

## Operation
- `access` = (`memread` | `memwrite`) & (`mem_length` != 00). If both `memread` and `memwrite` are high, `memwrite` wins.
- Misaligned conditions:
  - halfword with `addr[0]`=1
  - word with `addr[1:0]` != 00
- In IDLE, a misaligned access drives `addr_err`=1 and `stall`=0. No bus transaction is started and the state stays IDLE.
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ on an aligned access. On this transition, latch the following: `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, `addr[1:0]`, `mem_length`, `mem_signed`. Also clear the timeout counter.
- REQ: `bus_req`=1, and the counter increments every cycle.
  - On `bus_ack`: capture `bus_rdata` → go to DONE with `bus_err`=0.
  - On counter == `TIMEOUT` without ack: go to DONE with `bus_err`=1 and raw data 0.
- DONE: `done`=1 and `stall`=0. Always return to IDLE on the next edge.
- Byte enables (`bus_be`):
  - byte: 0001 shifted left by `addr[1:0]`
  - halfword: `addr[1]` ? 1100 : 0011
  - word: 1111
- Write data (`bus_wdata`):
  - byte: {4{`wdata[7:0]`}}
  - halfword: {2{`wdata[15:0]`}}
  - word: `wdata` unchanged
- Read extraction in DONE uses the latched offset:
  - byte: lane `addr[1:0]`
  - halfword: upper half if `addr[1]`=1, else lower half
  - the selected lane is extended to 32 bits with its MSB if `mem_signed`=1, otherwise with zeros
  - `rdata` is forced to 0 for stores and when `bus_err`=1.
- `bus_ack` is ignored in IDLE and DONE (stray or late acks).

## Timing
- Reset values: state = IDLE; all of `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `rdata`, `done`, `bus_err`, and the counter are 0.
- `stall` is combinational: (IDLE & aligned access) | REQ. It is high in the decode cycle itself, so the PC never advances past an unstarted access.
- Minimum latency: access is seen in cycle 0 (IDLE). REQ runs in cycle 1 with ack in that cycle. DONE is cycle 2. `stall` is high for cycles 0–1.
- Each extra wait cycle adds 1 to the latency.
- Bus outputs are registered and stay stable for the whole REQ phase.
- `bus_req` drops on the edge that samples the ack or the timeout.
- Worst case: `TIMEOUT` REQ cycles, then DONE.
- Back-to-back accesses: DONE is followed by IDLE, where the next instruction's access is evaluated. There is no dead bus cycle beyond DONE.
- Reset asserted in REQ: `bus_req`=0 from the next edge. The outstanding transaction is abandoned and a later ack is ignored.
- Non-memory instructions in IDLE: `stall`=0 and `done`=0.

## Structure
- Shared package `mem_pkg`:
  - size constants `MEM_NONE`=00, `MEM_BYTE`=01, `MEM_HALF`=10, `MEM_WORD`=11
  - FSM state encoding: IDLE, REQ, DONE
- Sub-module `mem_lane_align`, purely combinational:
  - store side: size + offset + `wdata` → `bus_be` and replicated write data
  - load side: size + offset + signed + raw word → extended `rdata`
  - also the misalignment check
- The top level holds the FSM, the latches, and the timeout counter.

## Test plan
- **SB:** `memwrite`, `mem_length`=01, `addr`=0x1003, `wdata`=0xAB, ack in first REQ cycle → `bus_addr`=0x1000, `be`=1000, `bus_wdata`=0xABABABAB. `done` in cycle 2.
- **LH signed:** `addr`=0x2002, `bus_rdata`=0x8001_1234, 2 wait cycles → `rdata`=0xFFFF8001 with `done` in cycle 4. With `mem_signed`=0 → `rdata`=0x00008001.
- **LW misaligned:** `addr`=0x2001 → `addr_err`=1, `stall`=0, `bus_req` never asserts.
- **Timeout:** `TIMEOUT`=4, no ack → `bus_req` high for 4 cycles, then `done`=1, `bus_err`=1, `rdata`=0.
- **Reset mid-REQ**, then ack on the following cycle → `bus_req`=0 and state IDLE after the reset edge, with no `done` pulse.
- **Back-to-back:** LBU 0x3001 (data 0x0000_F000 → `rdata`=0xF0), then SW 0x3004 → second `bus_req` rises in the cycle after DONE+1.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: access-size codes and sequencer state encoding shared by the memory access path
package mem_pkg;
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering for stores, lane extraction and extension for loads
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_len,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    input  logic [1:0]  ld_len,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ext,
    output logic        misaligned
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        be = st_len == MEM_BYTE ? 4'b0001 << st_off :
             st_len == MEM_HALF ? (st_off[1] ? 4'b1100 : 4'b0011) :
             st_len == MEM_WORD ? 4'b1111 : 4'b0000;
        wdata_rep = st_len == MEM_BYTE ? {4{wdata[7:0]}} :
                    st_len == MEM_HALF ? {2{wdata[15:0]}} : wdata;
        misaligned = (st_len == MEM_HALF && st_off[0]) || (st_len == MEM_WORD && st_off != 2'b00);
        b = raw[{ld_off, 3'b000} +: 8];
        h = ld_off[1] ? raw[31:16] : raw[15:0];
        ext = ld_len == MEM_BYTE ? {{24{ld_signed & b[7]}}, b} :
              ld_len == MEM_HALF ? {{16{ld_signed & h[15]}}, h} : raw;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one decoded load/store into a handshaked word bus transaction,
// stalling the pipeline until ack or timeout and returning extended load data
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [1:0]  mem_length,
    input  logic        mem_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);
    localparam logic [15:0] TO = 16'(TIMEOUT);
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, raw_q, raw_d;
    logic [1:0]  off_q, off_d, len_q, len_d;
    logic        sgn_q, sgn_d, done_q, done_d, bus_err_q, bus_err_d;
    logic        access, misal, go;
    logic [3:0]  be_n;
    logic [31:0] wd_n, ext;

    mem_lane_align u_align (
        .st_len(mem_length), .st_off(addr[1:0]), .wdata(wdata),
        .ld_len(len_q), .ld_off(off_q), .ld_signed(sgn_q), .raw(raw_q),
        .be(be_n), .wdata_rep(wd_n), .ext(ext), .misaligned(misal)
    );

    assign access    = (memread | memwrite) && mem_length != MEM_NONE;
    assign go        = state_q == IDLE && access && !misal;
    assign addr_err  = state_q == IDLE && access && misal;
    assign stall     = go || state_q == REQ;
    assign done      = done_q;
    assign bus_err   = bus_err_q;
    assign rdata     = (bus_we_q | bus_err_q) ? 32'h0 : ext;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        off_d       = off_q;
        len_d       = len_q;
        sgn_d       = sgn_q;
        raw_d       = raw_q;
        done_d      = 1'b0;
        bus_err_d   = 1'b0;
        if (state_q == IDLE) begin
            if (go) begin
                state_d     = REQ;
                bus_req_d   = 1'b1;
                bus_we_d    = memwrite;
                bus_be_d    = be_n;
                bus_addr_d  = {addr[31:2], 2'b00};
                bus_wdata_d = wd_n;
                off_d       = addr[1:0];
                len_d       = mem_length;
                sgn_d       = mem_signed;
                cnt_d       = 16'h0;
            end
        end else if (state_q == REQ) begin
            cnt_d = cnt_q + 16'd1;
            // the incremented count names this REQ cycle, so TIMEOUT=N gives exactly N request cycles
            if (bus_ack) begin
                state_d   = DONE;
                bus_req_d = 1'b0;
                done_d    = 1'b1;
                raw_d     = bus_rdata;
            end else if (cnt_d == TO) begin
                state_d   = DONE;
                bus_req_d = 1'b0;
                done_d    = 1'b1;
                bus_err_d = 1'b1;
                raw_d     = 32'h0;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            off_q       <= '0;
            len_q       <= '0;
            sgn_q       <= 1'b0;
            raw_q       <= '0;
            done_q      <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            off_q       <= off_d;
            len_q       <= len_d;
            sgn_q       <= sgn_d;
            raw_q       <= raw_d;
            done_q      <= done_d;
            bus_err_q   <= bus_err_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of load/store sequencing, alignment, timeout and reset abort
module tb_mem_access_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        memread = 1'b0, memwrite = 1'b0, mem_signed = 1'b0, bus_ack = 1'b0;
    logic [1:0]  mem_length = 2'b00;
    logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;
    logic        stall, done, addr_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    int          checks = 0, errors = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
        .mem_length(mem_length), .mem_signed(mem_signed), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata), .addr_err(addr_err), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] len, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
        memread = rd; memwrite = wr; mem_length = len; mem_signed = sgn; addr = a; wdata = wd;
        #1;
    endtask

    task automatic idle_in();
        memread = 1'b0; memwrite = 1'b0; mem_length = 2'b00; mem_signed = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_req", bus_req, 0); chk("rst_done", done, 0); chk("rst_be", bus_be, 0);
        chk("rst_addr", bus_addr, 0); chk("rst_wdata", bus_wdata, 0); chk("rst_rdata", rdata, 0);
        chk("rst_berr", bus_err, 0);
        rst = 1'b0;
        tick();
        chk("idle_stall", stall, 0);
        // SB 0x1003
        req(0, 1, 2'b01, 0, 32'h1003, 32'h0000_00AB);
        chk("sb_c0_stall", stall, 1); chk("sb_c0_aerr", addr_err, 0); chk("sb_c0_req", bus_req, 0);
        tick(); idle_in();
        chk("sb_req", bus_req, 1); chk("sb_we", bus_we, 1); chk("sb_addr", bus_addr, 32'h1000);
        chk("sb_be", bus_be, 4'b1000); chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        chk("sb_c1_stall", stall, 1); chk("sb_c1_done", done, 0);
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("sb_done", done, 1); chk("sb_req_drop", bus_req, 0); chk("sb_berr", bus_err, 0);
        chk("sb_rdata", rdata, 0); chk("sb_c2_stall", stall, 0);
        tick();
        chk("sb_done_pulse", done, 0);
        // LH signed 0x2002, two wait cycles
        req(1, 0, 2'b10, 1, 32'h2002, 0);
        tick(); idle_in();
        chk("lh_req", bus_req, 1); chk("lh_we", bus_we, 0); chk("lh_be", bus_be, 4'b1100);
        chk("lh_addr", bus_addr, 32'h2000);
        tick(); chk("lh_wait1", bus_req, 1);
        tick(); chk("lh_wait2", bus_req, 1); chk("lh_wait2_done", done, 0);
        bus_rdata = 32'h8001_1234; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lh_done", done, 1); chk("lh_rdata", rdata, 32'hFFFF_8001);
        tick();
        // LHU 0x2002
        req(1, 0, 2'b10, 0, 32'h2002, 0);
        tick(); idle_in(); bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lhu_done", done, 1); chk("lhu_rdata", rdata, 32'h0000_8001);
        tick();
        // LW misaligned
        req(1, 0, 2'b11, 0, 32'h2001, 0);
        chk("lw_mis_aerr", addr_err, 1); chk("lw_mis_stall", stall, 0);
        tick(); chk("lw_mis_req1", bus_req, 0); chk("lw_mis_aerr2", addr_err, 1);
        tick(); chk("lw_mis_req2", bus_req, 0); chk("lw_mis_done", done, 0);
        req(1, 0, 2'b10, 0, 32'h2003, 0);
        chk("lh_mis_aerr", addr_err, 1);
        req(1, 0, 2'b10, 0, 32'h2002, 0);
        chk("lh_ok_aerr", addr_err, 0);
        idle_in(); #1;
        chk("none_stall", stall, 0);
        tick();
        // timeout, no ack
        bus_rdata = 32'hDEAD_BEEF;
        req(1, 0, 2'b11, 1, 32'h4000, 0);
        tick(); idle_in();
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("to_req%0d", i), bus_req, 1);
            chk($sformatf("to_done%0d", i), done, 0);
            if (i < 4) tick();
        end
        tick();
        chk("to_done", done, 1); chk("to_berr", bus_err, 1); chk("to_rdata", rdata, 0);
        chk("to_req_drop", bus_req, 0);
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("late_ack_req", bus_req, 0); chk("late_ack_done", done, 0); chk("late_berr", bus_err, 0);
        tick();
        // reset in REQ, then ack
        req(1, 0, 2'b11, 0, 32'h5000, 0);
        tick(); idle_in();
        chk("rr_req", bus_req, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; bus_ack = 1'b1;
        chk("rr_req_drop", bus_req, 0); chk("rr_stall", stall, 0);
        tick(); bus_ack = 1'b0;
        chk("rr_done", done, 0); chk("rr_req2", bus_req, 0);
        tick(); chk("rr_done2", done, 0);
        // back-to-back LBU 0x3001 then SW 0x3004
        req(1, 0, 2'b01, 0, 32'h3001, 0);
        tick(); idle_in();
        chk("lbu_be", bus_be, 4'b0010);
        bus_rdata = 32'h0000_F000; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("lbu_done", done, 1); chk("lbu_rdata", rdata, 32'h0000_00F0);
        req(0, 1, 2'b11, 0, 32'h3004, 32'h1234_5678);
        chk("b2b_done_stall", stall, 0);
        tick();
        chk("b2b_idle_req", bus_req, 0); chk("b2b_idle_stall", stall, 1);
        tick(); idle_in();
        chk("b2b_req", bus_req, 1); chk("b2b_addr", bus_addr, 32'h3004);
        chk("b2b_be", bus_be, 4'b1111); chk("b2b_wdata", bus_wdata, 32'h1234_5678);
        bus_ack = 1'b1;
        tick(); bus_ack = 1'b0;
        chk("b2b_done", done, 1); chk("b2b_rdata", rdata, 0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
